// File: rtl/timer_arb_pkg.sv
// Shared types and defaults for the interval timer arbiter.
// Used by the top block and the round-robin picker.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 4;

    // Owner index width; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDX_W_DEF = idx_w(N_REQ_DEF);

endpackage

// File: rtl/interval_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or
// above the pointer, wrapping modulo N_REQ.
module rr_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             valid
);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        win   = '0;
        valid = |req;
        idx   = 0;
        sel   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = IDX_W'(idx);
            if (req[sel]) begin
                win = sel;
            end
        end
    end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shares one up-counter among N_REQ timer clients, granting
// round-robin and pulsing Done when each interval expires.
module interval_timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*CNT_W-1:0] Len,
    output logic [N_REQ-1:0]       Grant,
    output logic [N_REQ-1:0]       Done,
    output logic                   Busy,
    output logic [CNT_W-1:0]       Count
);

    localparam int IDX_W = idx_w(N_REQ);

    state_t           state_q, state_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [N_REQ-1:0] done_q, done_n;
    logic             busy_q, busy_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] len_q, len_n;
    logic [IDX_W-1:0] owner_q, owner_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [IDX_W-1:0] owner_inc;

    logic [CNT_W-1:0] len_a [N_REQ];
    logic [IDX_W-1:0] win;
    logic             win_valid;

    for (genvar i = 0; i < N_REQ; i++) begin : g_len
        assign len_a[i] = Len[i*CNT_W +: CNT_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (Req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_valid)
    );

    assign owner_inc = (owner_q == IDX_W'(N_REQ - 1))
                     ? '0 : owner_q + IDX_W'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            count_q <= count_n;
            len_q   <= len_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        done_n  = '0;
        busy_n  = busy_q;
        count_n = count_q;
        len_n   = len_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        unique case (state_q)
            IDLE: begin
                grant_n = '0;
                busy_n  = 1'b0;
                count_n = '0;
                if (win_valid) begin
                    owner_n      = win;
                    len_n        = len_a[win];
                    grant_n[win] = 1'b1;
                    busy_n       = 1'b1;
                    state_n      = RUN;
                end
            end
            RUN: begin
                // A dropped request wins over a same-edge completion.
                if (!Req[owner_q]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    count_n = '0;
                    ptr_n   = owner_inc;
                end else if (count_q == len_q) begin
                    state_n         = DONE;
                    done_n[owner_q] = 1'b1;
                    grant_n         = '0;
                    busy_n          = 1'b0;
                    count_n         = '0;
                end else begin
                    count_n = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                ptr_n   = owner_inc;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
                count_n = '0;
            end
        endcase
    end

    assign Grant = grant_q;
    assign Done  = done_q;
    assign Busy  = busy_q;
    assign Count = count_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter with
// hand-computed expectations.
module tb_interval_timer_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Req;
    logic [15:0] Len;
    logic [3:0]  Grant;
    logic [3:0]  Done;
    logic        Busy;
    logic [3:0]  Count;

    int checks = 0;
    int errors = 0;

    interval_timer_arbiter #(
        .N_REQ (4),
        .CNT_W (4)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Req   (Req),
        .Len   (Len),
        .Grant (Grant),
        .Done  (Done),
        .Busy  (Busy),
        .Count (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(Grant), 32'h0);
        chk({tag, "_done"}, 32'(Done), 32'h0);
        chk({tag, "_busy"}, 32'(Busy), 32'h0);
        chk({tag, "_count"}, 32'(Count), 32'h0);
    endtask

    initial begin
        logic [3:0] exp_g;

        // Reset held with all requests asserted.
        Reset = 1'b1;
        Req   = 4'b1111;
        Len   = 16'h0000;
        tick();
        tick();
        chk_idle("rst_hold");
        Reset = 1'b0;
        Req   = 4'b0000;
        tick();

        // Asynchronous reset pulse in the middle of a grant.
        Req = 4'b0100;
        Len = 16'h0700;
        tick();
        chk("pulse_pre_grant", 32'(Grant), 32'h4);
        chk("pulse_pre_busy", 32'(Busy), 32'h1);
        #2 Reset = 1'b1;
        #1;
        chk_idle("rst_pulse");
        Reset = 1'b0;
        Req   = 4'b0000;
        tick();

        // Single request, length 3.
        Len = 16'h0030;
        Req = 4'b0010;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("single_grant", 32'(Grant), 32'h2);
            chk("single_count", 32'(Count), 32'(k));
            chk("single_nodone", 32'(Done), 32'h0);
            tick();
        end
        chk("single_done", 32'(Done), 32'h2);
        chk("single_gone", 32'(Grant), 32'h0);
        Req = 4'b0000;
        tick();
        chk("single_done_clr", 32'(Done), 32'h0);

        // Return pointer to 0, then round-robin with all lengths 0.
        Reset = 1'b1;
        #1 Reset = 1'b0;
        Req = 4'b1111;
        Len = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            tick();
            chk("rr_grant", 32'(Grant), 32'(exp_g));
            chk("rr_nodone", 32'(Done), 32'h0);
            tick();
            chk("rr_done", 32'(Done), 32'(exp_g));
            chk("rr_gap1", 32'(Grant), 32'h0);
            tick();
            chk("rr_gap2", 32'(Grant), 32'h0);
            chk("rr_done_clr", 32'(Done), 32'h0);
        end
        Req = 4'b0000;

        // Abort requester 2 at Count 4; pointer moves to 3.
        Req = 4'b0100;
        Len = 16'h0A00;
        tick();
        chk("abort_grant", 32'(Grant), 32'h4);
        for (int k = 0; k < 4; k++) tick();
        chk("abort_count4", 32'(Count), 32'h4);
        Req = 4'b0000;
        tick();
        chk_idle("abort");
        Req = 4'b1101;
        tick();
        chk("abort_next", 32'(Grant), 32'h8);
        tick();
        chk("abort_next_done", 32'(Done), 32'h8);
        Req = 4'b0000;
        tick();

        // Max length 15; later Len change must be ignored.
        Len = 16'h000F;
        Req = 4'b0001;
        tick();
        Len = 16'h0002;
        for (int k = 0; k < 16; k++) begin
            chk("max_grant", 32'(Grant), 32'h1);
            chk("max_count", 32'(Count), 32'(k));
            chk("max_nodone", 32'(Done), 32'h0);
            tick();
        end
        chk("max_done", 32'(Done), 32'h1);
        chk("max_count_clr", 32'(Count), 32'h0);
        Req = 4'b0000;
        tick();
        chk("max_done_once", 32'(Done), 32'h0);

        // Reset during RUN at Count 5.
        Len = 16'h0090;
        Req = 4'b0010;
        tick();
        chk("midrun_grant", 32'(Grant), 32'h2);
        for (int k = 0; k < 5; k++) tick();
        chk("midrun_count5", 32'(Count), 32'h5);
        Reset = 1'b1;
        #1;
        chk_idle("midrun_rst");
        Req = 4'b1010;
        tick();
        chk_idle("midrun_hold");
        #2 Reset = 1'b0;
        tick();
        chk("midrun_regrant", 32'(Grant), 32'h2);
        chk("midrun_busy", 32'(Busy), 32'h1);
        Req = 4'b0000;
        tick();
        chk_idle("final_abort");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_arbiter.md
# interval_timer_arbiter

Round-robin controller that shares one 4-bit up-counter among N requesters. Each requester asks for a timed interval of programmable length. The block grants the counter to one requester at a time, counts the interval, then pulses a per-requester completion strobe. It sits between software-visible timer clients and the shared counter datapath, so the counter never needs duplicating per client.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter/length width
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clock Clock
- Req  in  N_REQ  level request per requester; must stay high until Done or abort
- Len  in  N_REQ*CNT_W  interval length per requester, slice i = Len[i*CNT_W +: CNT_W]
- Grant  out  N_REQ  one-hot owner of the counter, all-zero when idle
- Done  out  N_REQ  one-cycle completion pulse to the owner
- Busy  out  1  high while any Grant bit is high
- Count  out  CNT_W  current shared counter value

## Operation
- States: IDLE, RUN, DONE. Registered outputs only.
- Reset values: state IDLE, Grant 0, Done 0, Busy 0, Count 0, round-robin pointer 0, latched length 0, latched owner 0.
- IDLE:
  - If Req is nonzero, the arbiter picks the first set bit searching upward from the pointer, with modulo-N_REQ wrap.
  - On that edge: latch owner w, latch L = Len[w], set Grant to one-hot(w), set Busy to 1, set Count to 0, go to RUN.
- RUN:
  - Normal case: Count increments by 1 each edge while Count != L.
  - At the edge where Count == L: go to DONE, set Done[w] to 1, clear Grant/Busy, set Count to 0.
- Abort: if Req[w] is low at any RUN edge, go to IDLE, clear Grant/Busy, set Count to 0, and set pointer to (w+1) mod N_REQ. Done is never asserted. Abort takes priority over completion on the same edge.
- DONE: Done[w] is high for exactly this one cycle. Set pointer to (w+1) mod N_REQ and return to IDLE.
- Len changes after a grant are ignored because L is latched. The interval always uses the value present at the grant edge.
- Count never wraps: L ≤ 2^CNT_W − 1, so the interval ends at or before the all-ones value.
- Reset asserted in any state returns every register to its reset value immediately, without waiting for Clock. No Done is emitted for the interrupted interval.

## Timing
- Request to grant: 1 edge from IDLE.
- Grant duration: L+1 cycles, with Count showing 0..L. L = 0 gives a single-cycle grant.
- Done appears the cycle after the last grant cycle.
- Back-to-back service: Grant(n) falls, then there is one DONE cycle and one IDLE cycle, then Grant(n+1) rises. The minimum gap is 2 cycles.
- After an abort, the next grant can occur 1 IDLE cycle later.
- At most one Grant bit and one Done bit are high at any time, and Grant & Done == 0.

## Structure
- Shared package `timer_arb_pkg`:
  - state enum {IDLE, RUN, DONE}
  - default N_REQ/CNT_W localparams
  - owner-index width $clog2(N_REQ)
- Sub-module `rr_arbiter`: combinational. Inputs are Req and the pointer; outputs are the winner index and a valid bit. It is reusable elsewhere.
- The counter, FSM and latches live in the top block.

## Test plan
- Reset: hold Reset high with Req=4'b1111 -> Grant=0, Done=0, Busy=0, Count=0. Pulse Reset mid-cycle -> outputs clear before the next edge.
- Single request: Req[1]=1, Len[1]=3 -> Grant=4'b0010 for 4 cycles with Count 0,1,2,3. Done=4'b0010 for 1 cycle, then Grant=0.
- Round robin: Req=4'b1111, all Len=0 -> grants in order 0,1,2,3,0, each 1 cycle wide and followed by its Done pulse, 2-cycle gaps between grants.
- Abort: Req[2]=1, Len[2]=10, drop Req[2] when Count=4 -> Grant=0 next edge, Done stays 0. Next Req=4'b1101 grants requester 3.
- Max length: Len[0]=15 -> Count reaches 15 without wrap, Grant lasts 16 cycles, Done[0] pulses once.
- Reset mid-RUN: Req[1]=1, Len[1]=9, assert Reset at Count=5 -> all outputs 0, pointer 0. After release with Req=4'b1010, requester 1 is granted first.
